// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: byte width and feeder FSM states.
package uart_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } feeder_state_t;

endpackage

// File: rtl/uart_feeder_fifo.sv
// Byte FIFO for the UART feeder; DEPTH must be a power of two so pointers wrap naturally.
module uart_feeder_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [BYTE_W-1:0]      push_data_i,
    input  logic                   pop_i,
    output logic [BYTE_W-1:0]      head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Feeds queued bytes to a UART transmitter one at a time using a start/busy handshake.
// Define UART_FEEDER_TIMEOUT_EN to abandon a byte whose busy never rises (sets sticky err).
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned BUSY_WAIT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [BYTE_W-1:0]      in_data,
    output logic                   in_ready,
    output logic                   start,
    output logic [BYTE_W-1:0]      data,
    input  logic                   busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   idle,
    output logic                   err
);

    feeder_state_t     state_q, state_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic [BYTE_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              tmo_hit;

    uart_feeder_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (in_valid && in_ready),
        .push_data_i (in_data),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Reset overrides occupancy so upstream sees ready throughout reset.
    assign in_ready = rst || !fifo_full;
    assign start    = (state_q == LAUNCH);
    assign data     = data_q;
    assign idle     = !busy && (rst || (fifo_empty && state_q == IDLE));

`ifdef UART_FEEDER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(BUSY_WAIT + 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          err_q;

    assign tmo_hit = (state_q == WAIT_BUSY) && !busy && (tmo_cnt_q == TW'(BUSY_WAIT - 1));
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= (state_q == WAIT_BUSY) ? tmo_cnt_q + TW'(1) : '0;
            if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !busy) begin
                    pop     = 1'b1;
                    data_d  = fifo_head;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder with a simple UART busy model and a queue-based reference.
// Timeout scenario runs only when UART_FEEDER_TIMEOUT_EN is defined.
module tb_uart_tx_feeder;
    import uart_pkg::*;

    localparam int unsigned DEPTH     = 16;
    localparam int unsigned BUSY_WAIT = 8;
    localparam int unsigned CW        = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          start;
    logic [7:0]    data;
    logic          busy;
    logic [CW-1:0] count;
    logic          idle;
    logic          err;

    logic uart_busy  = 1'b0;
    logic force_busy = 1'b0;
    logic uart_en    = 1'b1;
    assign busy = uart_busy | force_busy;

    uart_tx_feeder #(
        .DEPTH     (DEPTH),
        .BUSY_WAIT (BUSY_WAIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .start    (start),
        .data     (data),
        .busy     (busy),
        .count    (count),
        .idle     (idle),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // UART transmit model: busy rises the cycle after start and lasts three cycles.
    logic [7:0] sent[$];
    int         start_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (start === 1'b1) begin
                start_cnt++;
                if (uart_en) begin
                    sent.push_back(data);
                    $display("sending data: 0x%02h", data);
                    @(posedge clk);
                    #1 uart_busy = 1'b1;
                    repeat (3) @(posedge clk);
                    #1 uart_busy = 1'b0;
                end
            end
        end
    end

    // Reference: queue of waiting bytes plus one transmitter slot that is
    // launched, then waits for busy to rise and fall before freeing up.
    logic [7:0] mq[$];
    bit         m_ok     = 1'b0;
    bit         m_launch = 1'b0;
    logic [7:0] m_data   = 8'h00;
    int         m_phase  = 0;
    bit         m_err    = 1'b0;
    int         m_tc     = 0;
    bit         m_pop;
    bit         m_push;

    initial begin
        forever begin
            @(negedge clk);
            if (m_ok) begin
                chk("count", 32'(count), 32'(mq.size()));
                chk("in_ready", 32'(in_ready), 32'(rst || (mq.size() < DEPTH)));
                chk("start", 32'(start), 32'(m_launch));
                chk("data", 32'(data), 32'(m_data));
                chk("idle", 32'(idle),
                    32'(!busy && (rst || (mq.size() == 0 && !m_launch && m_phase == 0))));
                chk("err", 32'(err), 32'(m_err));
            end
            if (rst) begin
                mq.delete();
                m_launch = 1'b0;
                m_data   = 8'h00;
                m_phase  = 0;
                m_err    = 1'b0;
                m_tc     = 0;
                m_ok     = 1'b1;
            end else begin
                m_pop  = !m_launch && m_phase == 0 && mq.size() > 0 && !busy;
                m_push = in_valid && (mq.size() < DEPTH);
                if (m_phase == 1) begin
                    if (busy) begin
                        m_phase = 2;
                    end else begin
`ifdef UART_FEEDER_TIMEOUT_EN
                        m_tc++;
                        if (m_tc == BUSY_WAIT) begin
                            m_phase = 0;
                            m_err   = 1'b1;
                        end
`endif
                    end
                end else if (m_phase == 2 && !busy) begin
                    m_phase = 0;
                end
                if (m_launch) begin
                    m_phase = 1;
                    m_tc    = 0;
                end
                m_launch = m_pop;
                if (m_pop) begin
                    m_data = mq.pop_front();
                end
                if (m_push) begin
                    mq.push_back(in_data);
                end
            end
        end
    end

    task automatic push1(input logic [7:0] b);
        @(posedge clk);
        #1 in_valid = 1'b1;
        in_data = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (idle !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(idle), 32'd1);
    endtask

    task automatic wait_start(input string nm);
        int k = 0;
        @(negedge clk);
        while (start !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(start), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int s0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_err", 32'(err), 32'd0);

        // Single byte: accepted in cycle N, start in N+2
        push1(8'hA5);
        @(negedge clk);
        chk("lat_n1_start", 32'(start), 32'd0);
        @(negedge clk);
        chk("lat_n2_start", 32'(start), 32'd1);
        chk("lat_n2_data", 32'(data), 32'hA5);
        wait_idle("single_idle");
        chk("single_sent_n", 32'(sent.size()), 32'd1);
        if (sent.size() > 0) chk("single_sent_byte", 32'(sent[0]), 32'hA5);

        // Burst of 16 with busy held so the FIFO fills, then hold in_valid while full
        sent.delete();
        @(posedge clk);
        #1 force_busy = 1'b1;
        for (int b = 1; b <= 16; b++) begin
            in_valid = 1'b1;
            in_data  = 8'(b);
            @(posedge clk);
            #1;
        end
        in_data = 8'hEE;
        @(negedge clk);
        chk("full_count", 32'(count), 32'd16);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("full_hold_count", 32'(count), 32'd16);
        @(posedge clk);
        #1 force_busy = 1'b0;
        @(negedge clk);
        chk("pop_cycle_count", 32'(count), 32'd16);
        @(negedge clk);
        chk("after_pop_count", 32'(count), 32'd15);
        chk("after_pop_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("refill_count", 32'(count), 32'd16);
        chk("refill_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        k = 0;
        while (sent.size() < 17 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("burst_sent_n", 32'(sent.size()), 32'd17);
        for (int i = 0; i < 16; i++) begin
            if (i < sent.size()) chk("burst_order", 32'(sent[i]), 32'(i + 1));
        end
        if (sent.size() > 16) chk("burst_last", 32'(sent[16]), 32'hEE);
        wait_idle("burst_idle");

        // Busy preasserted: no launch until busy falls, then one cycle later
        @(posedge clk);
        #1 force_busy = 1'b1;
        push1(8'h77);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("busy_hold_start", 32'(start), 32'd0);
        end
        chk("busy_hold_count", 32'(count), 32'd1);
        @(posedge clk);
        #1 force_busy = 1'b0;
        @(negedge clk);
        chk("busy_fall_start", 32'(start), 32'd0);
        @(negedge clk);
        chk("busy_fall_start1", 32'(start), 32'd1);
        chk("busy_fall_data", 32'(data), 32'h77);
        wait_idle("busy_idle");

        // Reset during WAIT_DONE with five queued bytes
        uart_en = 1'b0;
        push1(8'h90);
        wait_start("mid_launch");
        @(posedge clk);
        #1 force_busy = 1'b1;
        for (int b = 0; b < 5; b++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hC0 + b);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_queued", 32'(count), 32'd5);
        s0 = start_cnt;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        force_busy = 1'b0;
        @(negedge clk);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_start", 32'(start), 32'd0);
        chk("mid_rst_data", 32'(data), 32'h00);
        repeat (20) @(negedge clk);
        chk("mid_no_start", 32'(start_cnt), 32'(s0));
        uart_en = 1'b1;

`ifdef UART_FEEDER_TIMEOUT_EN
        // Timeout: busy never rises, err set at N+11, next byte still goes out
        uart_en = 1'b0;
        push1(8'h3C);
        @(negedge clk);
        chk("tmo_n1_start", 32'(start), 32'd0);
        @(negedge clk);
        chk("tmo_n2_start", 32'(start), 32'd1);
        chk("tmo_n2_data", 32'(data), 32'h3C);
        repeat (8) @(negedge clk);
        chk("tmo_n10_err", 32'(err), 32'd0);
        @(negedge clk);
        chk("tmo_n11_err", 32'(err), 32'd1);
        chk("tmo_n11_idle", 32'(idle), 32'd1);
        uart_en = 1'b1;
        sent.delete();
        push1(8'h4B);
        wait_idle("tmo_next_idle");
        chk("tmo_next_sent", 32'(sent.size()), 32'd1);
        if (sent.size() > 0) chk("tmo_next_byte", 32'(sent[0]), 32'h4B);
        chk("tmo_err_sticky", 32'(err), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("tmo_err_cleared", 32'(err), 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
